vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port, double-buffered framebuffer RAM between three users: display scan-out (fed by the 640x360 timing generator) and two drawing clients.
- Display fetch has absolute priority. The two writers share all remaining cycles round-robin.
- Sequences front/back buffer swaps so a swap only ever happens at end-of-screen.
- Sits between the VGA timing generator, the drawing engines and the framebuffer BRAM.

Parameters:
- FB_W, 320, framebuffer width in pixels (display is 2x pixel- and line-doubled).
- FB_H, 180, framebuffer height in pixels.
- ADDR_W, 16, per-bank address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- DATA_W, 8, pixel width in bits.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_pix_stb  in  1  pixel strobe, same as the timing generator's.
- i_active  in  1  timing generator active-pixel flag.
- i_screenend  in  1  one-tick end-of-screen pulse.
- i_x  in  10  active x position, 0..639.
- i_y  in  9  active y position, 0..359.
- i_swap_req  in  1  pulse: request a buffer swap.
- o_swap_done  out  1  one-cycle pulse when the swap takes effect.
- o_front  out  1  bank currently displayed.
- i_c0_req / i_c1_req  in  1  client write request, level, held until granted.
- i_c0_addr / i_c1_addr  in  ADDR_W  pixel address within the back bank.
- i_c0_data / i_c1_data  in  DATA_W  write data.
- o_c0_gnt / o_c1_gnt  out  1  one-cycle pulse; the write is performed in that cycle.
- o_mem_addr  out  ADDR_W+1  RAM address; MSB is the bank.
- o_mem_we  out  1  RAM write enable.
- o_mem_wdata  out  DATA_W  RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address.
- o_pix  out  DATA_W  registered display pixel.

Behaviour:
- **Reset.** Synchronous on i_rst. Sets o_front=0, swap_pending=0, rr_last=1 (client 0 wins first), o_pix=0. All grants, o_mem_we and o_swap_done are 0. o_mem_addr=0.
- **Reset mid-operation.** An in-flight write completes in the reset cycle only if it was granted in an earlier cycle. No grant is ever issued in a reset cycle.
- **RAM port.** Combinational per cycle from the arbitration decision.
- **Display fetch slot (fetch=1).** Occurs when i_pix_stb & i_active & (i_x[0]==0).
  - o_mem_addr = {o_front, (i_y>>1)*FB_W + (i_x>>1)}.
  - o_mem_we=0; no client is granted that cycle.
  - The multiply is constant; shift-add (256+64 for 320) is acceptable.
- **Pixel output.** rd_valid is fetch delayed 1 cycle. o_pix <= i_mem_rdata in the cycle after the fetch, so o_pix updates 2 cycles after the fetch and then holds.
- **Write arbitration (fetch=0).** Round-robin between requesting clients:
  - If only one client requests, it is granted.
  - If both request, the client not equal to rr_last is granted.
  - rr_last updates to the granted client.
  - On grant: o_mem_addr={~o_front, ci_addr}, o_mem_we=1, o_mem_wdata=ci_data, o_ci_gnt=1.
  - No request: o_mem_we=0.
- **Out-of-range write.** If ci_addr >= FB_W*FB_H, the client is still granted (it must not hang), but o_mem_we=0.
- **Back-to-back.** A client keeping req high after a grant may be granted again next cycle if the other client is idle.
- **Starvation bound.** Display takes at most 1 of every 2 pix_stb events. With one pix_stb every 4 clocks, each requesting client is granted within 4 cycles.
- **Swap sequencing.**
  - i_swap_req sets swap_pending; repeated requests are idempotent.
  - A cycle with i_screenend & (swap_pending | i_swap_req) is the swap cycle: o_front <= ~o_front, swap_pending <= 0, o_swap_done=1.
  - A write granted in the swap cycle targets the pre-swap back bank; writes granted from the next cycle target the new back bank.
  - A swap request arriving in the cycle after screenend waits for the next screenend.

Decomposition:
- Package vga_fb_pkg holds FB_W, FB_H, FB_SIZE=FB_W*FB_H, a client-index enum (C0, C1) and the display-address function.
- One sub-module is natural: rr_arb2, a 2-way round-robin arbiter (inputs req[1:0] and block; outputs gnt[1:0]; holds rr_last).

Test Plan:
1. **Reset.** Assert i_rst with c0_req=1 -> no gnt, o_mem_we=0, o_front=0, o_pix=0 through the reset cycle.
2. **Display priority.** i_active=1, i_x=10, i_y=7, pix_stb, c0_req=1 -> o_mem_addr={0,3*320+5=965}, no gnt that cycle. c0 is granted next cycle with o_mem_addr MSB=1. o_pix equals i_mem_rdata@965 two cycles after the fetch.
3. **Round-robin.** c0_req=c1_req=1 held, no fetches -> gnt sequence c0,c1,c0,c1. Drop c1 -> c0 is granted every cycle.
4. **Swap.** swap_req pulse mid-frame -> o_front unchanged until i_screenend. At screenend, o_swap_done=1 and o_front=1. A c0 write in that same cycle has addr MSB=1; a c0 write next cycle has MSB=0.
5. **Swap edge cases.** swap_req coincident with screenend -> swap in that cycle. Two swap_reqs in one frame -> a single swap.
6. **Out-of-range write.** c1_addr=57600 -> o_c1_gnt=1, o_mem_we=0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants, client index type and display address helper for the
// framebuffer arbiter slice.
package vga_fb_pkg;

  localparam int unsigned FB_W    = 320;
  localparam int unsigned FB_H    = 180;
  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic {
    C0 = 1'b0,
    C1 = 1'b1
  } client_e;

  // Display is 2x pixel- and line-doubled, so halve both coordinates.
  function automatic int unsigned disp_addr(input int unsigned fb_w,
                                            input logic [9:0]  x,
                                            input logic [8:0]  y);
    return 32'(y[8:1]) * fb_w + 32'(x[9:1]);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between timing generator / drawing clients / framebuffer RAM
// and the arbiter. slave = arbiter side, master = environment side.
//   timing : i_pix_stb, i_active, i_screenend, i_x, i_y
//   swap   : i_swap_req, o_swap_done, o_front
//   client : i_cN_req, i_cN_addr, i_cN_data, o_cN_gnt (N = 0, 1)
//   memory : o_mem_addr, o_mem_we, o_mem_wdata, i_mem_rdata
//   display: o_pix
interface vga_fb_arbiter_if
  import vga_fb_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
);

  logic          i_pix_stb;
  logic          i_active;
  logic          i_screenend;
  logic [9:0]    i_x;
  logic [8:0]    i_y;

  logic          i_swap_req;
  logic          o_swap_done;
  logic          o_front;

  logic          i_c0_req;
  logic [AW-1:0] i_c0_addr;
  logic [DW-1:0] i_c0_data;
  logic          o_c0_gnt;
  logic          i_c1_req;
  logic [AW-1:0] i_c1_addr;
  logic [DW-1:0] i_c1_data;
  logic          o_c1_gnt;

  logic [AW:0]   o_mem_addr;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  logic [DW-1:0] o_pix;

  modport slave (
    input  i_pix_stb, i_active, i_screenend, i_x, i_y,
    input  i_swap_req,
    output o_swap_done, o_front,
    input  i_c0_req, i_c0_addr, i_c0_data,
    output o_c0_gnt,
    input  i_c1_req, i_c1_addr, i_c1_data,
    output o_c1_gnt,
    output o_mem_addr, o_mem_we, o_mem_wdata,
    input  i_mem_rdata,
    output o_pix
  );

  modport master (
    output i_pix_stb, i_active, i_screenend, i_x, i_y,
    output i_swap_req,
    input  o_swap_done, o_front,
    output i_c0_req, i_c0_addr, i_c0_data,
    input  o_c0_gnt,
    output i_c1_req, i_c1_addr, i_c1_data,
    input  o_c1_gnt,
    input  o_mem_addr, o_mem_we, o_mem_wdata,
    output i_mem_rdata,
    input  o_pix
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a blocking input.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req[1:0]   : client requests (bit N = client N)
//   i_block      : suppress all grants this cycle (display slot / reset)
//   o_gnt[1:0]   : combinational one-hot grant for this cycle
module rr_arb2
  import vga_fb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_block,
  output logic [1:0] o_gnt
);

  client_e rr_last_q;
  client_e rr_last_d;

  // Grant selection; on contention the client that did not win last goes.
  always_comb begin
    o_gnt     = 2'b00;
    rr_last_d = rr_last_q;
    if (!i_block) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (rr_last_q == C1) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
      if (o_gnt[0]) begin
        rr_last_d = C0;
      end else if (o_gnt[1]) begin
        rr_last_d = C1;
      end
    end
  end

  // Reset to C1 so client 0 wins the first contended cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_q <= C1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch has absolute priority, two
// drawing clients share the remaining cycles round-robin, and front/back
// bank swaps are deferred to end-of-screen.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : vga_fb_arbiter_if.slave (timing, swap, clients, RAM, pixel)
// RAM port, grants and o_swap_done are combinational for the current cycle;
// o_front and o_pix are registered.
module vga_fb_arbiter #(
  parameter int unsigned FB_W   = vga_fb_pkg::FB_W,
  parameter int unsigned FB_H   = vga_fb_pkg::FB_H,
  parameter int unsigned ADDR_W = vga_fb_pkg::ADDR_W,
  parameter int unsigned DATA_W = vga_fb_pkg::DATA_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  vga_fb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_W * FB_H);

  logic              front_q, front_d;
  logic              swap_pending_q, swap_pending_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] pix_q, pix_d;

  logic              fetch_c;
  logic [1:0]        gnt_c;
  logic [ADDR_W:0]   mem_addr_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              swap_done_c;

  // Even x of an active strobe is a fetch; odd x reuses the doubled pixel.
  assign fetch_c = bus.i_pix_stb & bus.i_active & ~bus.i_x[0];

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   ({bus.i_c1_req, bus.i_c0_req}),
    .i_block (fetch_c | i_rst),
    .o_gnt   (gnt_c)
  );

  // RAM port steering and swap detection for this cycle.
  always_comb begin
    mem_addr_c  = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    swap_done_c = 1'b0;
    if (!i_rst) begin
      if (fetch_c) begin
        mem_addr_c = {front_q,
                      ADDR_W'(vga_fb_pkg::disp_addr(FB_W, bus.i_x, bus.i_y))};
      end else if (gnt_c[0]) begin
        // Out-of-range writes are granted so the client cannot hang.
        mem_addr_c  = {~front_q, bus.i_c0_addr};
        mem_we_c    = (bus.i_c0_addr < FB_LIMIT);
        mem_wdata_c = bus.i_c0_data;
      end else if (gnt_c[1]) begin
        mem_addr_c  = {~front_q, bus.i_c1_addr};
        mem_we_c    = (bus.i_c1_addr < FB_LIMIT);
        mem_wdata_c = bus.i_c1_data;
      end
      swap_done_c = bus.i_screenend & (swap_pending_q | bus.i_swap_req);
    end
  end

  // Next-state for bank selection and the pixel pipeline.
  always_comb begin
    front_d        = front_q;
    swap_pending_d = swap_pending_q;
    rd_valid_d     = fetch_c;
    pix_d          = rd_valid_q ? bus.i_mem_rdata : pix_q;
    if (swap_done_c) begin
      front_d        = ~front_q;
      swap_pending_d = 1'b0;
    end else if (bus.i_swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      pix_q          <= '0;
    end else begin
      front_q        <= front_d;
      swap_pending_q <= swap_pending_d;
      rd_valid_q     <= rd_valid_d;
      pix_q          <= pix_d;
    end
  end

  assign bus.o_c0_gnt    = gnt_c[0];
  assign bus.o_c1_gnt    = gnt_c[1];
  assign bus.o_mem_addr  = mem_addr_c;
  assign bus.o_mem_we    = mem_we_c;
  assign bus.o_mem_wdata = mem_wdata_c;
  assign bus.o_swap_done = swap_done_c;
  assign bus.o_front     = front_q;
  assign bus.o_pix       = pix_q;

endmodule
